// File: rtl/line_sequencer.sv
// rtl/line_sequencer.sv - line store that presents words one at a time on a line_done handshake
// Optional per-line WAIT timeout is built only when LINE_SEQ_TIMEOUT_EN is defined.
module line_sequencer #(
    parameter int WIDTH   = 25,
    parameter int DEPTH   = 64,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             start_i,
    input  logic             line_done_i,
    output logic [WIDTH-1:0] line_o,
    output logic             line_valid_o,
    output logic [AW-1:0]    line_idx_o,
    output logic             busy_o,
    output logic             finished_o,
    output logic             err_timeout_o
);

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, WAIT, FINISH} state_t;

    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] EOF_WORD = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] line_q, line_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;
    logic             tmo;
    logic             advance;
    logic             is_eof;

    // Storage is deliberately outside the reset domain so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_q <= mem[idx_q];
    end

`ifdef LINE_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == CHECK) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tmo = (state_q == WAIT) && !line_done_i && (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT;
    assign tmo = 1'b0;
`endif

    assign is_eof  = (rd_q == EOF_WORD);
    assign advance = (state_q == WAIT) && (line_done_i || tmo);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   state_d = CHECK;
            CHECK:   state_d = is_eof ? FINISH : WAIT;
            WAIT:    if (advance) state_d = (idx_q == LAST_IDX) ? FINISH : FETCH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_d  = line_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d = '0;
                    err_d = 1'b0;
                end
            end
            CHECK: begin
                if (!is_eof) begin
                    line_d  = rd_q;
                    valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (tmo) err_d = 1'b1;
                if (advance) begin
                    valid_d = 1'b0;
                    if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            line_q  <= line_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign line_o        = line_q;
    assign line_valid_o  = valid_q;
    assign line_idx_o    = idx_q;
    assign busy_o        = (state_q != IDLE);
    assign finished_o    = (state_q == FINISH);
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_line_sequencer.sv
// tb/tb_line_sequencer.sv - directed self-checking bench for line_sequencer
module tb_line_sequencer;

    localparam int W  = 25;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam logic [W-1:0] EOF_W = {W{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          line_done = 1'b0;
    logic [W-1:0]  line;
    logic          line_valid;
    logic [AW-1:0] line_idx;
    logic          busy;
    logic          finished;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .start_i      (start),
        .line_done_i  (line_done),
        .line_o       (line),
        .line_valid_o (line_valid),
        .line_idx_o   (line_idx),
        .busy_o       (busy),
        .finished_o   (finished),
        .err_timeout_o(err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic done_pulse();
        line_done = 1'b1;
        step();
        line_done = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!line_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (!finished && c < 3000) begin
            if (line_valid) line_done = 1'b1;
            step();
            line_done = 1'b0;
            c++;
        end
        check("drain_finished", finished, 1);
        step();
    endtask

    // Expects stored value idx+1 at each presented index; start already accepted.
    task automatic run_lines(input int n, input int fin_lat, input int fin_idx);
        int lat;
        int fl;
        logic ok;
        logic sawv;
        logic [W-1:0] held;
        check("busy_after_start", busy, 1);
        for (int k = 0; k < n; k++) begin
            wait_valid(lat);
            check("line_latency", lat, 2);
            check("line_value", line, k + 1);
            check("line_idx", line_idx, k);
            held = line;
            ok = 1'b1;
            repeat (4) begin
                step();
                if (!line_valid || line !== held) ok = 1'b0;
            end
            check("line_held", ok, 1);
            done_pulse();
            check("valid_drop", line_valid, 0);
        end
        fl = 0;
        sawv = 1'b0;
        while (!finished && fl < 20) begin
            step();
            fl++;
            if (line_valid) sawv = 1'b1;
        end
        check("finish_latency", fl, fin_lat);
        check("eof_not_valid", sawv, 0);
        check("finish_idx", line_idx, fin_idx);
        check("line_kept", line, n);
        step();
        check("finish_one_cycle", finished, 0);
        check("back_idle", busy, 0);
    endtask

    initial begin
        int lat;
        int n;
        logic fin_seen;
        logic v_seen;
        logic ok;

        repeat (2) @(posedge clk);
        #1;
        check("rst_line", line, 0);
        check("rst_valid", line_valid, 0);
        check("rst_idx", line_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        step();

        // EOF at index 2; write of mem[0] coincides with the accepted start
        wr(1, 25'h0000002);
        wr(2, EOF_W);
        wr(0, EOF_W);
        wr_en = 1'b1; wr_addr = '0; wr_data = 25'h0000001; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        run_lines(2, 2, 2);

        // Full table, no EOF: stops after the last entry without wrapping
        for (int i = 0; i < D; i++) wr(i, W'(i + 1));
        pulse_start();
        run_lines(D, 0, D - 1);

        // Asynchronous reset while waiting on index 5
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            wait_valid(lat);
            done_pulse();
        end
        wait_valid(lat);
        check("pre_rst_idx", line_idx, 5);
        check("pre_rst_line", line, 6);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", line_valid, 0);
        check("async_rst_line", line, 0);
        check("async_rst_idx", line_idx, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_finished", finished, 0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        wait_valid(lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_idx", line_idx, 0);
        check("post_rst_line", line, 1);
        drain();

        // Write, start and line_done while in FETCH are all ignored
        pulse_start();
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 25'h0AAAAAA; start = 1'b1; line_done = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0; line_done = 1'b0;
        check("busy_in_check", busy, 1);
        wait_valid(lat);
        check("busy_inputs_latency", lat, 1);
        check("busy_inputs_line", line, 1);
        check("busy_inputs_idx", line_idx, 0);
        for (int k = 0; k < 3; k++) begin
            done_pulse();
            wait_valid(lat);
        end
        check("dropped_write_idx", line_idx, 3);
        check("dropped_write_line", line, 4);
        drain();

`ifdef LINE_SEQ_TIMEOUT_EN
        pulse_start();
        wait_valid(lat);
        repeat (7) step();
        check("tmo_not_yet_err", err_timeout, 0);
        check("tmo_not_yet_valid", line_valid, 1);
        step();
        check("tmo_err", err_timeout, 1);
        check("tmo_valid_drop", line_valid, 0);
        wait_valid(lat);
        check("tmo_next_latency", lat, 2);
        check("tmo_next_idx", line_idx, 1);
        check("tmo_next_line", line, 2);
        check("tmo_sticky", err_timeout, 1);
        drain();
        check("tmo_sticky_idle", err_timeout, 1);
        pulse_start();
        check("tmo_cleared", err_timeout, 0);
        drain();
`else
        pulse_start();
        wait_valid(lat);
        ok = 1'b1;
        repeat (100) begin
            step();
            if (!line_valid || err_timeout) ok = 1'b0;
        end
        check("no_timeout_hold", ok, 1);
        check("no_timeout_idx", line_idx, 0);
        drain();
`endif

        // EOF at address 0: nothing presented, three busy cycles
        wr(0, EOF_W);
        pulse_start();
        n = 0;
        fin_seen = 1'b0;
        v_seen = 1'b0;
        while (busy && n < 10) begin
            n++;
            if (finished) fin_seen = 1'b1;
            if (line_valid) v_seen = 1'b1;
            step();
        end
        check("eof0_busy_cycles", n, 3);
        check("eof0_finished", fin_seen, 1);
        check("eof0_no_valid", v_seen, 0);
        check("eof0_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
